// File: rtl/super_palette_pkg.sv
// Shared types and helpers for the super-res palette: write-sequencer state,
// packed RGB entry layout and the RGB332 default-palette expansion.
package super_palette_pkg;

    localparam int PALETTE_ENTRIES = 256;

    typedef enum logic [1:0] {
        IDLE_R = 2'd0,
        HAVE_R = 2'd1,
        HAVE_G = 2'd2
    } wr_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24_t;

    // Bit-replicate an RGB332 index into a full 8-bit-per-channel colour.
    function automatic rgb24_t rgb332_expand(input logic [7:0] idx);
        rgb24_t c;
        c.r = {idx[7:5], idx[7:5], idx[7:6]};
        c.g = {idx[4:2], idx[4:2], idx[4:3]};
        c.b = {4{idx[1:0]}};
        return c;
    endfunction

endpackage

// File: rtl/super_palette_ram.sv
// Dual-port synchronous palette RAM. Port A is the display read; port B is
// the CPU/init write plus an enabled read. Read-before-write on every port.
module super_palette_ram #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr_a,
    output logic [DATA_W-1:0] q_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic              we_b,
    input  logic [DATA_W-1:0] d_b,
    input  logic              re_b,
    output logic [DATA_W-1:0] q_b
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Display read port: registered, sees the pre-write contents.
    always_ff @(posedge clk) begin
        q_a <= mem[addr_a];
    end

    // Write/readback port: whole-entry write, optional registered read.
    always_ff @(posedge clk) begin
        if (we_b) mem[addr_b] <= d_b;
        if (re_b) q_b <= mem[addr_b];
    end

endmodule

// File: rtl/vdp_super_palette.sv
// Super-res palette: 1-clock registered display lookup, CPU index/data
// triplet loader with auto-increment, and a post-reset RGB332 fill sweep.
// Optional CPU readback path is enabled by defining SUPER_PALETTE_READBACK_EN.
module vdp_super_palette
    import super_palette_pkg::*;
#(
    parameter int ENTRIES               = PALETTE_ENTRIES,
    parameter int INIT_CYCLES_PER_ENTRY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] PALETTE_ADDR2,
    output logic [7:0] PALETTE_DATA_R2_OUT,
    output logic [7:0] PALETTE_DATA_G2_OUT,
    output logic [7:0] PALETTE_DATA_B2_OUT,
    input  logic       cpu_index_wr,
    input  logic       cpu_data_wr,
    input  logic [7:0] cpu_data,
    output logic       init_busy,
    output logic [7:0] cpu_rd_data,
    input  logic       cpu_data_rd
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    logic             init_busy_r;
    logic [IDX_W-1:0] init_cnt;
    logic             init_phase;
    logic             init_step;

    wr_state_t        wr_state;
    logic [IDX_W-1:0] wr_index;
    logic [7:0]       r_lat;
    logic [7:0]       g_lat;
    logic             cpu_commit;

    logic             blank_p1;
    rgb24_t           disp_p1;
    rgb24_t           rdbk_p1;

    logic [IDX_W-1:0] addr_b;
    logic             we_b;
    rgb24_t           d_b;
    logic             re_b;

    assign init_busy  = init_busy_r;
    assign init_step  = init_busy_r && ((INIT_CYCLES_PER_ENTRY == 1) || init_phase);
    assign cpu_commit = !init_busy_r && cpu_data_wr && !cpu_index_wr && (wr_state == HAVE_G);

`ifdef SUPER_PALETTE_READBACK_EN
    logic [1:0] rd_phase;
    logic [1:0] rd_sel;
    logic       rd_zero;
    assign re_b = !init_busy_r && cpu_data_rd && !cpu_index_wr && !cpu_data_wr;
`else
    assign re_b = 1'b0;
`endif

    // Port B is owned by the init sweep while it runs, otherwise by CPU commits.
    always_comb begin
        addr_b = wr_index;
        we_b   = cpu_commit;
        d_b    = '{r: r_lat, g: g_lat, b: cpu_data};
        if (init_busy_r) begin
            addr_b = init_cnt;
            we_b   = init_step;
            d_b    = rgb332_expand(8'(init_cnt));
        end
    end

    super_palette_ram #(
        .DEPTH  (ENTRIES),
        .ADDR_W (IDX_W),
        .DATA_W (24)
    ) u_ram (
        .clk    (clk),
        .addr_a (PALETTE_ADDR2[IDX_W-1:0]),
        .q_a    (disp_p1),
        .addr_b (addr_b),
        .we_b   (we_b),
        .d_b    (d_b),
        .re_b   (re_b),
        .q_b    (rdbk_p1)
    );

    // Init sweep: walk every entry once after reset, then release the palette.
    always_ff @(posedge clk) begin
        if (reset) begin
            init_busy_r <= 1'b1;
            init_cnt    <= '0;
            init_phase  <= 1'b0;
        end else if (init_busy_r) begin
            init_phase <= !init_step;
            if (init_step) begin
                init_cnt <= init_cnt + IDX_W'(1);
                if (init_cnt == LAST_IDX) init_busy_r <= 1'b0;
            end
        end
    end

    // CPU write sequencer: index load, then R, G, B bytes committing one entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state <= IDLE_R;
            wr_index <= '0;
            r_lat    <= 8'h00;
            g_lat    <= 8'h00;
`ifdef SUPER_PALETTE_READBACK_EN
            rd_phase <= 2'd0;
            rd_sel   <= 2'd0;
            rd_zero  <= 1'b1;
`endif
        end else if (init_busy_r) begin
`ifdef SUPER_PALETTE_READBACK_EN
            if (cpu_data_rd) rd_zero <= 1'b1;
`endif
        end else if (cpu_index_wr) begin
            wr_index <= cpu_data[IDX_W-1:0];
            wr_state <= IDLE_R;
            r_lat    <= 8'h00;
            g_lat    <= 8'h00;
`ifdef SUPER_PALETTE_READBACK_EN
            rd_phase <= 2'd0;
`endif
        end else if (cpu_data_wr) begin
            case (wr_state)
                IDLE_R: begin
                    r_lat    <= cpu_data;
                    wr_state <= HAVE_R;
                end
                HAVE_R: begin
                    g_lat    <= cpu_data;
                    wr_state <= HAVE_G;
                end
                HAVE_G: begin
                    wr_index <= wr_index + IDX_W'(1);
                    wr_state <= IDLE_R;
                end
                default: wr_state <= IDLE_R;
            endcase
        end
`ifdef SUPER_PALETTE_READBACK_EN
        else if (cpu_data_rd) begin
            rd_zero <= 1'b0;
            rd_sel  <= rd_phase;
            if (rd_phase == 2'd2) begin
                rd_phase <= 2'd0;
                wr_index <= wr_index + IDX_W'(1);
            end else begin
                rd_phase <= rd_phase + 2'd1;
            end
        end
`endif
    end

    // Blank the display while the sweep is running or just after reset.
    always_ff @(posedge clk) begin
        blank_p1 <= reset | init_busy_r;
    end

    assign PALETTE_DATA_R2_OUT = blank_p1 ? 8'h00 : disp_p1.r;
    assign PALETTE_DATA_G2_OUT = blank_p1 ? 8'h00 : disp_p1.g;
    assign PALETTE_DATA_B2_OUT = blank_p1 ? 8'h00 : disp_p1.b;

`ifdef SUPER_PALETTE_READBACK_EN
    // Select the byte of the latched entry matching the phase of the strobe.
    always_comb begin
        cpu_rd_data = 8'h00;
        if (!rd_zero) begin
            case (rd_sel)
                2'd0:    cpu_rd_data = rdbk_p1.r;
                2'd1:    cpu_rd_data = rdbk_p1.g;
                default: cpu_rd_data = rdbk_p1.b;
            endcase
        end
    end
`else
    logic unused_rdbk;
    assign unused_rdbk = ^{cpu_data_rd, rdbk_p1};
    assign cpu_rd_data = 8'h00;
`endif

endmodule

// File: tb/tb_vdp_super_palette.sv
// Directed bench for vdp_super_palette: init sweep, CPU triplet writes,
// wrap, partial-triplet discard, read-before-write, reset mid-sweep.
module tb_vdp_super_palette;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] PALETTE_ADDR2 = 8'h00;
    logic [7:0] PALETTE_DATA_R2_OUT;
    logic [7:0] PALETTE_DATA_G2_OUT;
    logic [7:0] PALETTE_DATA_B2_OUT;
    logic       cpu_index_wr = 1'b0;
    logic       cpu_data_wr = 1'b0;
    logic [7:0] cpu_data = 8'h00;
    logic       init_busy;
    logic [7:0] cpu_rd_data;
    logic       cpu_data_rd = 1'b0;

    int checks = 0;
    int errors = 0;

    vdp_super_palette dut (
        .clk                 (clk),
        .reset               (reset),
        .PALETTE_ADDR2       (PALETTE_ADDR2),
        .PALETTE_DATA_R2_OUT (PALETTE_DATA_R2_OUT),
        .PALETTE_DATA_G2_OUT (PALETTE_DATA_G2_OUT),
        .PALETTE_DATA_B2_OUT (PALETTE_DATA_B2_OUT),
        .cpu_index_wr        (cpu_index_wr),
        .cpu_data_wr         (cpu_data_wr),
        .cpu_data            (cpu_data),
        .init_busy           (init_busy),
        .cpu_rd_data         (cpu_rd_data),
        .cpu_data_rd         (cpu_data_rd)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_idx(input logic [7:0] v);
        cpu_index_wr = 1'b1;
        cpu_data     = v;
        tick();
        cpu_index_wr = 1'b0;
    endtask

    task automatic cpu_byte(input logic [7:0] v);
        cpu_data_wr = 1'b1;
        cpu_data    = v;
        tick();
        cpu_data_wr = 1'b0;
    endtask

    task automatic read_pix(input logic [7:0] a, output logic [23:0] v);
        PALETTE_ADDR2 = a;
        tick();
        v = {PALETTE_DATA_R2_OUT, PALETTE_DATA_G2_OUT, PALETTE_DATA_B2_OUT};
    endtask

    // Count clocks until init_busy drops; optionally fire CPU strobes meanwhile.
    task automatic wait_init(input bit strobes, output int n);
        n = 0;
        while (init_busy === 1'b1 && n < 400) begin
            if (strobes) begin
                cpu_index_wr = (n == 5);
                cpu_data_wr  = (n >= 6 && n <= 8);
                cpu_data_rd  = (n == 9);
                cpu_data     = (n == 5) ? 8'h60 : 8'h11;
            end
            tick();
            n++;
        end
        cpu_index_wr = 1'b0;
        cpu_data_wr  = 1'b0;
        cpu_data_rd  = 1'b0;
    endtask

    task automatic test_reset();
        logic [23:0] v;
        int n;
        reset = 1'b1;
        tick();
        tick();
        v = {PALETTE_DATA_R2_OUT, PALETTE_DATA_G2_OUT, PALETTE_DATA_B2_OUT};
        checks++;
        if (v !== 24'h000000) begin
            errors++;
            $display("FAIL reset_outputs got %h want 000000", v);
        end
        checks++;
        if (init_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy got %b want 1", init_busy);
        end
        checks++;
        if (cpu_rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_rd_data got %h want 00", cpu_rd_data);
        end
        reset = 1'b0;
        PALETTE_ADDR2 = 8'hE3;
        wait_init(1'b0, n);
        checks++;
        if (n != 256) begin
            errors++;
            $display("FAIL init_cycles got %0d want 256", n);
        end
    endtask

    task automatic test_default_palette();
        logic [23:0] v;
        read_pix(8'hE3, v);
        checks++;
        if (v !== 24'hFF00FF) begin
            errors++;
            $display("FAIL default_e3 got %h want ff00ff", v);
        end
        read_pix(8'h00, v);
        checks++;
        if (v !== 24'h000000) begin
            errors++;
            $display("FAIL default_00 got %h want 000000", v);
        end
        read_pix(8'h5A, v);
        checks++;
        if (v !== 24'h49DBAA) begin
            errors++;
            $display("FAIL default_5a got %h want 49dbaa", v);
        end
    endtask

    task automatic test_cpu_write();
        logic [23:0] v;
        cpu_idx(8'h10);
        cpu_byte(8'h12);
        cpu_byte(8'h34);
        cpu_byte(8'h56);
        read_pix(8'h00, v);
        read_pix(8'h10, v);
        checks++;
        if (v !== 24'h123456) begin
            errors++;
            $display("FAIL write_10 got %h want 123456", v);
        end
        cpu_byte(8'h77);
        cpu_byte(8'h88);
        cpu_byte(8'h99);
        read_pix(8'h11, v);
        checks++;
        if (v !== 24'h778899) begin
            errors++;
            $display("FAIL autoinc_11 got %h want 778899", v);
        end
    endtask

    task automatic test_wrap();
        logic [23:0] v;
        cpu_idx(8'hFF);
        cpu_byte(8'hA1);
        cpu_byte(8'hA2);
        cpu_byte(8'hA3);
        cpu_byte(8'hB1);
        cpu_byte(8'hB2);
        cpu_byte(8'hB3);
        read_pix(8'hFF, v);
        checks++;
        if (v !== 24'hA1A2A3) begin
            errors++;
            $display("FAIL wrap_ff got %h want a1a2a3", v);
        end
        read_pix(8'h00, v);
        checks++;
        if (v !== 24'hB1B2B3) begin
            errors++;
            $display("FAIL wrap_00 got %h want b1b2b3", v);
        end
        read_pix(8'h01, v);
        checks++;
        if (v !== 24'h000055) begin
            errors++;
            $display("FAIL wrap_01_untouched got %h want 000055", v);
        end
    endtask

    task automatic test_partial_discard();
        logic [23:0] v;
        cpu_idx(8'h20);
        cpu_byte(8'hAA);
        cpu_byte(8'hBB);
        cpu_idx(8'h20);
        cpu_byte(8'h01);
        cpu_byte(8'h02);
        cpu_byte(8'h03);
        read_pix(8'h20, v);
        checks++;
        if (v !== 24'h010203) begin
            errors++;
            $display("FAIL partial_20 got %h want 010203", v);
        end
        // index strobe and data strobe together: the byte must be dropped
        cpu_index_wr = 1'b1;
        cpu_data_wr  = 1'b1;
        cpu_data     = 8'h40;
        tick();
        cpu_index_wr = 1'b0;
        cpu_data_wr  = 1'b0;
        cpu_byte(8'h0C);
        cpu_byte(8'h0D);
        cpu_byte(8'h0E);
        read_pix(8'h40, v);
        checks++;
        if (v !== 24'h0C0D0E) begin
            errors++;
            $display("FAIL idx_wins_40 got %h want 0c0d0e", v);
        end
    endtask

    task automatic test_read_before_write();
        logic [23:0] v;
        PALETTE_ADDR2 = 8'h30;
        cpu_idx(8'h30);
        cpu_byte(8'hC1);
        cpu_byte(8'hC2);
        cpu_byte(8'hC3);
        v = {PALETTE_DATA_R2_OUT, PALETTE_DATA_G2_OUT, PALETTE_DATA_B2_OUT};
        checks++;
        if (v !== 24'h249200) begin
            errors++;
            $display("FAIL rbw_old got %h want 249200", v);
        end
        tick();
        v = {PALETTE_DATA_R2_OUT, PALETTE_DATA_G2_OUT, PALETTE_DATA_B2_OUT};
        checks++;
        if (v !== 24'hC1C2C3) begin
            errors++;
            $display("FAIL rbw_new got %h want c1c2c3", v);
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] v;
        int n;
        cpu_idx(8'h50);
        cpu_byte(8'hEE);
        PALETTE_ADDR2 = 8'hE3;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        v = {PALETTE_DATA_R2_OUT, PALETTE_DATA_G2_OUT, PALETTE_DATA_B2_OUT};
        checks++;
        if (v !== 24'h000000) begin
            errors++;
            $display("FAIL midtriplet_reset_out got %h want 000000", v);
        end
        repeat (100) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        v = {PALETTE_DATA_R2_OUT, PALETTE_DATA_G2_OUT, PALETTE_DATA_B2_OUT};
        checks++;
        if (v !== 24'h000000 || init_busy !== 1'b1) begin
            errors++;
            $display("FAIL midsweep_reset got %h busy %b want 000000 busy 1", v, init_busy);
        end
        wait_init(1'b1, n);
        checks++;
        if (n != 256) begin
            errors++;
            $display("FAIL restart_cycles got %0d want 256", n);
        end
        read_pix(8'h10, v);
        checks++;
        if (v !== 24'h009200) begin
            errors++;
            $display("FAIL refill_10 got %h want 009200", v);
        end
        read_pix(8'h60, v);
        checks++;
        if (v !== 24'h6D0000) begin
            errors++;
            $display("FAIL ignored_strobes_60 got %h want 6d0000", v);
        end
        // index back at 0 and state at IDLE_R despite the abandoned triplet
        cpu_byte(8'hD1);
        cpu_byte(8'hD2);
        cpu_byte(8'hD3);
        read_pix(8'h00, v);
        checks++;
        if (v !== 24'hD1D2D3) begin
            errors++;
            $display("FAIL reset_index_00 got %h want d1d2d3", v);
        end
    endtask

    task automatic test_readback();
        logic [7:0] exp_b [3];
        exp_b[0] = 8'h12;
        exp_b[1] = 8'h34;
        exp_b[2] = 8'h56;
        cpu_idx(8'h10);
        cpu_byte(8'h12);
        cpu_byte(8'h34);
        cpu_byte(8'h56);
        cpu_idx(8'h10);
`ifdef SUPER_PALETTE_READBACK_EN
        for (int i = 0; i < 3; i++) begin
            cpu_data_rd = 1'b1;
            tick();
            cpu_data_rd = 1'b0;
            checks++;
            if (cpu_rd_data !== exp_b[i]) begin
                errors++;
                $display("FAIL readback_byte%0d got %h want %h", i, cpu_rd_data, exp_b[i]);
            end
        end
`else
        cpu_data_rd = 1'b1;
        tick();
        cpu_data_rd = 1'b0;
        checks++;
        if (cpu_rd_data !== 8'h00) begin
            errors++;
            $display("FAIL readback_disabled got %h want 00 (first byte would be %h)", cpu_rd_data, exp_b[0]);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_default_palette();
        test_cpu_write();
        test_wrap();
        test_partial_discard();
        test_read_before_write();
        test_reset_mid();
        test_readback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vdp_super_palette.md
Name: vdp_super_palette

Overview:
- 256-entry x 24-bit RGB palette serving the super-res/super-mid pixel path.
- Takes the 8-bit pixel index `PALETTE_ADDR2` from the super-res fetch stage and returns R/G/B one clock later.
- CPU side loads entries through an index/data register pair: index write, then three data bytes in R, G, B order, with auto-increment.
- After reset, a sweep sequencer fills every entry with an RGB332-expanded default palette.

Parameters:
- ENTRIES, 256, palette depth (power of two; index width = log2).
- INIT_CYCLES_PER_ENTRY, 1, clocks spent per entry during the init sweep (1 or 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- PALETTE_ADDR2  in  8  display pixel index.
- PALETTE_DATA_R2_OUT  out  8  red for the index presented one cycle earlier.
- PALETTE_DATA_G2_OUT  out  8  green, same timing.
- PALETTE_DATA_B2_OUT  out  8  blue, same timing.
- cpu_index_wr  in  1  one-cycle strobe: load write index from cpu_data.
- cpu_data_wr  in  1  one-cycle strobe: cpu_data is the next colour byte.
- cpu_data  in  8  CPU byte.
- init_busy  out  1  high while the init sweep runs.
- cpu_rd_data  out  8  readback byte (only with SUPER_PALETTE_READBACK_EN; otherwise tied 0).
- cpu_data_rd  in  1  readback strobe (only with SUPER_PALETTE_READBACK_EN; otherwise ignored).

Behaviour:
- Storage: three 256x8 arrays, or one 256x24 array. Synchronous read. Port A: display read. Port B: CPU/init write (plus readback read).
- Display read:
  - Latency is exactly 1 clk: `PALETTE_ADDR2` sampled at edge N produces data on the outputs after edge N.
  - Outputs are registered.
  - While init_busy=1, outputs are forced to 0.
- Write state machine, states IDLE_R, HAVE_R, HAVE_G:
  - cpu_index_wr: index <= cpu_data; state <= IDLE_R; any partial R/G latches are discarded.
  - cpu_data_wr in IDLE_R: latch R, go to HAVE_R.
  - cpu_data_wr in HAVE_R: latch G, go to HAVE_G.
  - cpu_data_wr in HAVE_G: write {R, G, cpu_data} to entry[index] in one cycle; index <= index+1, wrapping 255 -> 0; state <= IDLE_R.
  - A committed entry is never partially updated.
- Simultaneous events:
  - cpu_index_wr and cpu_data_wr in the same cycle: the index write wins and the data byte is dropped.
  - Display read and commit to the same address in the same cycle: display gets the old value (read-before-write). The new value is visible from the next read.
- Init sweep:
  - Entered on reset. init_busy=1; counter 0..255; one entry per INIT_CYCLES_PER_ENTRY clocks.
  - Entry i = R {i[7:5],i[7:5],i[7:6]}, G {i[4:2],i[4:2],i[4:3]}, B {i[1:0] x4}.
  - init_busy falls the cycle after entry 255 is written (256 clocks when INIT_CYCLES_PER_ENTRY=1).
  - CPU strobes during init are ignored; index and state stay at reset values.
- Reset (synchronous, any time including mid-sweep or mid-triplet):
  - Outputs 0, index 0, state IDLE_R, R/G latches 0, cpu_rd_data 0.
  - Init sweep restarts at entry 0.
- Width rules: index and counter are 8-bit, with explicit wrap. No arithmetic on colour bytes.

Optional Feature:
- Macro: SUPER_PALETTE_READBACK_EN.
- Defined:
  - cpu_data_rd returns bytes of entry[index] in R, G, B order through a separate read phase counter (0..2).
  - cpu_rd_data is valid 1 clk after the strobe.
  - After the B byte, index increments (wrap).
  - cpu_index_wr resets the read phase.
  - Readback during init_busy returns 0 and does not advance.
- Undefined: no readback logic; cpu_rd_data tied 0; cpu_data_rd unused.

Decomposition:
- Package super_palette_pkg:
  - typedef of the write state enum.
  - typedef of a struct packed rgb24 {r, g, b}.
  - function rgb332_expand(index) -> rgb24.
  - constant PALETTE_ENTRIES = 256.
- One sub-module, super_palette_ram: dual-port 256x24 synchronous RAM, read-before-write, inferable as block RAM.
- Sequencers stay in the top level.

Test Plan:
- Reset, wait 256 clks -> init_busy low at cycle 256. Then read index 0xE3 -> R=0xFF, G=0x00, B=0xFF; index 0x00 -> 0,0,0.
- cpu_index_wr 0x10; data 0x12, 0x34, 0x56 -> entry 0x10 = 12/34/56. A display read of 0x10 shows it with 1 clk latency; internal index = 0x11.
- Index 0xFF, write two full triplets -> entries 0xFF and 0x00 updated (wrap); entry 0x01 unchanged.
- Index 0x20; data 0xAA, 0xBB; then cpu_index_wr 0x20; data 0x01, 0x02, 0x03 -> entry 0x20 = 01/02/03 (partial triplet discarded).
- Hold PALETTE_ADDR2=0x30 while committing a new value to 0x30 -> old value on that cycle's output, new value the next cycle.
- Assert reset mid-sweep at entry 100 and mid-triplet -> outputs 0, init restarts, CPU strobes ignored until init_busy falls. With SUPER_PALETTE_READBACK_EN, reading back entry 0x10 yields 12, 34, 56.
